// File: rtl/db_scheduler_pkg.sv
// Shared types and default widths for the display-buffer frame-memory scheduler.
// Imported by the scheduler interface, the UART write FIFO and the scheduler top.
package db_scheduler_pkg;

  localparam int DB_ADDR_W     = 16;
  localparam int DB_DATA_W     = 8;
  localparam int DB_FIFO_DEPTH = 4;

  // Owner of the RAM port for the coming cycle.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VGA,
    ST_UART,
    ST_VBLANK
  } db_state_e;

  // One buffered UART write.
  typedef struct packed {
    logic [DB_ADDR_W-1:0] addr;
    logic [DB_DATA_W-1:0] data;
  } db_wr_entry_t;

endpackage

// File: rtl/db_scheduler_if.sv
// Bundle of every non-clock signal of db_scheduler: VGA read port, UART write port,
// RAM port, DB status lines and FIFO level. The scheduler uses the slave view.
interface db_scheduler_if
  import db_scheduler_pkg::*;
#(
  parameter int ADDR_W     = DB_ADDR_W,
  parameter int DATA_W     = DB_DATA_W,
  parameter int FIFO_DEPTH = DB_FIFO_DEPTH
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              hs_in;
  logic              vs_in;

  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic              vga_rd_valid;
  logic [DATA_W-1:0] vga_rd_data;

  logic              uart_wr_valid;
  logic [ADDR_W-1:0] uart_wr_addr;
  logic [DATA_W-1:0] uart_wr_data;
  logic              uart_wr_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              HS;
  logic              VS;
  logic              DF_UART;
  logic              DF_VGA;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  hs_in, vs_in,
    input  vga_rd_req, vga_rd_addr,
    output vga_rd_valid, vga_rd_data,
    input  uart_wr_valid, uart_wr_addr, uart_wr_data,
    output uart_wr_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output HS, VS, DF_UART, DF_VGA, fifo_level
  );

  modport master (
    output hs_in, vs_in,
    output vga_rd_req, vga_rd_addr,
    input  vga_rd_valid, vga_rd_data,
    output uart_wr_valid, uart_wr_addr, uart_wr_data,
    input  uart_wr_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  HS, VS, DF_UART, DF_VGA, fifo_level
  );

endinterface

// File: rtl/db_wr_fifo.sv
// Synchronous FIFO of UART write entries. When empty, the head shows the entry being
// pushed so a same-cycle push and pop pass straight through without being stored.
module db_wr_fifo
  import db_scheduler_pkg::*;
#(
  parameter  int DEPTH = DB_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  db_wr_entry_t     push_entry,
  input  logic             pop,
  output db_wr_entry_t     head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  db_wr_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign head    = empty ? push_entry : mem[rd_ptr];
  assign bypass  = empty && push && pop;
  assign do_push = push && !full && !bypass;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; pointers and level alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/db_scheduler.sv
// Frame-memory scheduler: one single-port RAM shared by the VGA reader (strict priority)
// and a buffered UART write path that drains on idle cycles and during vertical blanking.
module db_scheduler
  import db_scheduler_pkg::*;
#(
  parameter int ADDR_W     = DB_ADDR_W,
  parameter int DATA_W     = DB_DATA_W,
  parameter int FIFO_DEPTH = DB_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst_n,
  db_scheduler_if.slave bus
);

  db_state_e         state;
  db_state_e         state_nxt;

  db_wr_entry_t      push_entry;
  db_wr_entry_t      head;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_avail;

  logic              en_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              rd_valid;

  assign bus.uart_wr_ready = rst_n && !fifo_full;
  assign push              = bus.uart_wr_valid && bus.uart_wr_ready;
  assign push_entry        = '{addr: bus.uart_wr_addr, data: bus.uart_wr_data};
  // A write offered this cycle counts as pending, so an idle RAM takes it with no extra cycle.
  assign wr_avail          = !fifo_empty || push;
  assign pop               = (state_nxt == ST_UART) || (state_nxt == ST_VBLANK);

  db_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (bus.fifo_level)
  );

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = ST_IDLE;
    en_nxt    = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = '0;
    wdata_nxt = '0;

    if (bus.vga_rd_req) begin
      state_nxt = ST_VGA;
    end else if ((state == ST_VBLANK) && !(bus.vs_in && wr_avail)) begin
      // Blanking drain ends on an empty buffer or a falling vs_in; rest one cycle.
      state_nxt = ST_IDLE;
    end else if (wr_avail) begin
      state_nxt = bus.vs_in ? ST_VBLANK : ST_UART;
    end

    case (state_nxt)
      ST_VGA: begin
        en_nxt   = 1'b1;
        addr_nxt = bus.vga_rd_addr;
      end
      ST_UART, ST_VBLANK: begin
        en_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = head.addr;
        wdata_nxt = head.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.DF_VGA    <= 1'b0;
      bus.DF_UART   <= 1'b0;
      bus.HS        <= 1'b0;
      bus.VS        <= 1'b0;
      rd_valid      <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.mem_en    <= en_nxt;
      bus.mem_we    <= we_nxt;
      bus.mem_addr  <= addr_nxt;
      bus.mem_wdata <= wdata_nxt;
      bus.DF_VGA    <= (state_nxt == ST_VGA);
      bus.DF_UART   <= we_nxt;
      bus.HS        <= bus.hs_in;
      bus.VS        <= bus.vs_in;
      // The RAM answers the read granted this cycle one edge later.
      rd_valid      <= bus.DF_VGA;
    end
  end

  assign bus.vga_rd_valid = rd_valid;
  assign bus.vga_rd_data  = rd_valid ? bus.mem_rdata : '0;

  a_df_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.DF_VGA && bus.DF_UART));

  a_level_bound : assert property (@(posedge clk) disable iff (!rst_n)
    int'(bus.fifo_level) <= FIFO_DEPTH);

endmodule

// File: tb/tb_db_scheduler.sv
// Self-checking bench for db_scheduler: directed scenarios plus random traffic, with a
// transaction-level model feeding expectation queues that a negedge monitor consumes.
`timescale 1ns/1ps
module tb_db_scheduler;
  import db_scheduler_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t         gnt_q[$];   // read grants expected on the RAM port
  exp_t         rd_q[$];    // read data expected on vga_rd_valid
  exp_t         wr_q[$];    // RAM writes expected
  db_wr_entry_t pend[$];    // model of writes waiting for the RAM
  bit           in_vblank = 1'b0;
  bit           prev_hs = 1'b0;
  bit           prev_vs = 1'b0;
  bit           prev_rst = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  db_scheduler_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  db_scheduler #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Synchronous RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram_word(bus.mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of inputs and advance the reference model by that cycle.
  task automatic step(input bit rst, input bit hs, input bit vs, input bit req,
                      input logic [AW-1:0] ra, input bit wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    db_wr_entry_t e;
    @(posedge clk);
    #2;
    check("fifo_level", 32'(bus.fifo_level), 32'(pend.size()));
    check("uart_wr_ready", 32'(bus.uart_wr_ready), 32'(rst_n && (pend.size() < DEPTH)));
    prev_hs  = bus.hs_in;
    prev_vs  = bus.vs_in;
    prev_rst = rst_n;

    rst_n             = rst;
    bus.hs_in         = hs;
    bus.vs_in         = vs;
    bus.vga_rd_req    = req;
    bus.vga_rd_addr   = ra;
    bus.uart_wr_valid = wv;
    bus.uart_wr_addr  = wa;
    bus.uart_wr_data  = wd;

    if (!rst) begin
      pend.delete();
      in_vblank = 1'b0;
      // Anything the reset edge would have produced is discarded.
      while (gnt_q.size() > 0 && gnt_q[$].cyc > cyc) void'(gnt_q.pop_back());
      while (rd_q.size() > 0 && rd_q[$].cyc > cyc) void'(rd_q.pop_back());
      while (wr_q.size() > 0 && wr_q[$].cyc > cyc) void'(wr_q.pop_back());
    end else begin
      if (wv && pend.size() < DEPTH) pend.push_back('{addr: wa, data: wd});
      if (req) begin
        gnt_q.push_back('{cyc + 1, ra, '0});
        rd_q.push_back('{cyc + 2, ra, ram_word(ra)});
        in_vblank = 1'b0;
      end else if (pend.size() > 0 && !(in_vblank && !vs)) begin
        e = pend.pop_front();
        wr_q.push_back('{cyc + 1, e.addr, e.data});
        in_vblank = vs;
      end else begin
        in_vblank = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input bit vs);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, vs, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Monitor: compare every DUT-side event against the head of its expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (!prev_rst) begin
      check("reset_flags", {25'b0, bus.mem_en, bus.mem_we, bus.DF_UART, bus.DF_VGA,
                            bus.HS, bus.VS, bus.vga_rd_valid}, 32'h0);
      check("reset_bus", {bus.mem_addr, bus.mem_wdata, bus.vga_rd_data}, 32'h0);
    end else begin
      check("HS", 32'(bus.HS), 32'(prev_hs));
      check("VS", 32'(bus.VS), 32'(prev_vs));
    end

    while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
      e = wr_q.pop_front();
      check("wr_missing", 32'(e.cyc), 32'(cyc));
    end
    if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
      e = wr_q.pop_front();
      check("wr_grant", {28'b0, bus.mem_en, bus.mem_we, bus.DF_UART, bus.DF_VGA}, 32'hE);
      check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
      check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
    end else begin
      check("no_wr", {30'b0, bus.mem_we, bus.DF_UART}, 32'h0);
    end

    while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc) begin
      e = gnt_q.pop_front();
      check("rd_grant_missing", 32'(e.cyc), 32'(cyc));
    end
    if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
      e = gnt_q.pop_front();
      check("rd_grant", {28'b0, bus.mem_en, bus.mem_we, bus.DF_UART, bus.DF_VGA}, 32'h9);
      check("rd_addr", 32'(bus.mem_addr), 32'(e.addr));
    end else begin
      check("no_rd_grant", 32'(bus.DF_VGA), 32'h0);
    end

    while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      e = rd_q.pop_front();
      check("rd_valid_missing", 32'(e.cyc), 32'(cyc));
    end
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      e = rd_q.pop_front();
      check("rd_valid", 32'(bus.vga_rd_valid), 32'h1);
      check("rd_data", 32'(bus.vga_rd_data), 32'(e.data));
    end else begin
      check("no_rd_valid", 32'(bus.vga_rd_valid), 32'h0);
    end
  end

  initial begin
    int req_pct;
    bus.hs_in = 1'b0;          bus.vs_in = 1'b0;
    bus.vga_rd_req = 1'b0;     bus.vga_rd_addr = '0;
    bus.uart_wr_valid = 1'b0;  bus.uart_wr_addr = '0;  bus.uart_wr_data = '0;

    // Reset held for 3 cycles under random inputs.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom),
           1'($urandom), AW'($urandom), DW'($urandom));
    idle(2, 1'b0);

    // Back-to-back VGA reads.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, AW'(16'h0010 + i), 1'b0, '0, '0);
    idle(4, 1'b0);

    // VGA and UART in the same cycle: VGA first, write on the next idle cycle.
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0200, 1'b1, 16'h0100, 8'hAA);
    idle(3, 1'b0);

    // Backpressure: six offers under continuous reads, four accepted.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1, AW'(16'h0300 + i), 1'b1, AW'(16'h0400 + i), DW'(8'h50 + i));
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0306, 1'b0, '0, '0);
    idle(6, 1'b0);

    // Vertical blanking drain of three queued writes.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1, AW'(16'h0500 + i), 1'b1, AW'(16'h0600 + i), DW'(8'hC0 + i));
    idle(5, 1'b1);
    idle(3, 1'b0);

    // Reset one cycle after a read grant with two writes queued.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b0, 1'b0, 1'b1, AW'(16'h0700 + i), 1'b1, AW'(16'h0800 + i), DW'(8'h30 + i));
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0702, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0703, 1'b1, 16'h0900, 8'h11);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 16'h0901, 8'h12);
    idle(4, 1'b0);

    // Random traffic with bursty read load, blanking runs and occasional resets.
    req_pct = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0:       req_pct = 0;
          1:       req_pct = 30;
          2:       req_pct = 70;
          default: req_pct = 100;
        endcase
      end
      step(($urandom_range(0, 199) != 0), 1'($urandom),
           ($urandom_range(0, 15) == 0) ? !bus.vs_in : bus.vs_in,
           ($urandom_range(0, 99) < req_pct), AW'($urandom),
           ($urandom_range(0, 99) < 60), AW'($urandom), DW'($urandom));
    end
    idle(12, 1'b0);

    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    check("model_fifo_drained", 32'(bus.fifo_level), 32'(pend.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/db_scheduler.md
# db_scheduler

Shared frame-memory scheduler for the display-buffer (DB) subsystem. It arbitrates one single-port synchronous RAM between the VGA pixel reader, which has strict priority, and the UART write path. UART writes are buffered in a small FIFO and drained when the VGA reader is idle, with forced draining during vertical blanking. The block drives the DB status lines HS, VS, DF_UART and DF_VGA consumed by the DB monitor.

## Interface
Parameters:
- ADDR_W, 16, frame-memory address width
- DATA_W, 8, pixel/data width
- FIFO_DEPTH, 4, UART write-buffer depth (power of 2, ≥2)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- hs_in  in  1  horizontal sync from VGA timing generator (active-high pulse)
- vs_in  in  1  vertical sync / vertical blanking indicator (active-high)
- vga_rd_req  in  1  VGA read request, one word per cycle
- vga_rd_addr  in  ADDR_W  VGA read address
- vga_rd_valid  out  1  read data valid
- vga_rd_data  out  DATA_W  read data
- uart_wr_valid  in  1  UART write offer
- uart_wr_addr  in  ADDR_W  UART write address
- uart_wr_data  in  DATA_W  UART write data
- uart_wr_ready  out  1  FIFO can accept; equals !full
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  (1-cycle read latency)
- HS, VS  out  1  registered copies of hs_in/vs_in, aligned with grant outputs
- DF_UART, DF_VGA  out  1  grant flags: requester owning the RAM this cycle
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries pending

## Operation
- FSM states: ST_IDLE, ST_VGA, ST_UART, ST_VBLANK. State is evaluated each cycle from the inputs sampled in that cycle.
- ST_VBLANK is entered when vs_in=1 and the FIFO is non-empty. The FIFO then drains one entry per cycle. VGA requests are still honoured first. ST_VBLANK exits to ST_IDLE when the FIFO is empty or vs_in=0.
- Otherwise the priority order is:
  - vga_rd_req=1 → ST_VGA
  - FIFO non-empty → ST_UART
  - else ST_IDLE
- Grant outputs are registered:
  - ST_VGA: mem_en=1, mem_we=0, mem_addr=sampled vga_rd_addr, DF_VGA=1
  - ST_UART / ST_VBLANK drain: mem_en=1, mem_we=1, mem_addr/mem_wdata taken from the FIFO head, DF_UART=1, pop
  - ST_IDLE: mem_en=0
- DF_VGA and DF_UART are never both 1.
- FIFO push fires when uart_wr_valid && uart_wr_ready.
  - A push and a pop in the same cycle leave the level unchanged.
  - When full, a same-cycle pop does not raise ready in that cycle (ready depends on the current level only).
- Writes leave the FIFO in order. Read-after-write to the same address is not forwarded.
- Reset (rst_n=0 at posedge), including mid-operation, clears:
  - FSM to ST_IDLE
  - FIFO pointers, with the level forced to 0
  - mem_en, mem_we, DF_*, HS, VS, vga_rd_valid to 0
  - mem_addr, mem_wdata, vga_rd_data to 0
- An in-flight read is discarded by reset: vga_rd_valid stays 0 in the cycle after reset.
- uart_wr_ready is 0 while rst_n=0 and 1 afterwards.

## Timing
- VGA read: request sampled at edge N; mem_en/DF_VGA high in N+1; vga_rd_valid=1 with vga_rd_data=mem_rdata in N+2. Latency 2, throughput 1 per cycle.
- UART write: accepted at edge N into an empty FIFO with no VGA request; mem_we/DF_UART high in N+1 (latency 1).
- HS/VS lag hs_in/vs_in by exactly 1 cycle, matching the DF_* alignment.
- Continuous vga_rd_req starves the UART path. The FIFO then fills and uart_wr_ready falls; no write is ever dropped.

## Structure
- Add to DB_item_pack:
  - db_state_e enum
  - localparams for the default widths
  - a packed db_wr_entry_t struct {addr, data}
- One sub-module, db_wr_fifo: synchronous FIFO of db_wr_entry_t with push/pop, full/empty and level outputs.
- db_scheduler contains the FSM, the output registers and the read-valid pipeline.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → all outputs 0 and fifo_level=0; uart_wr_ready=1 the cycle after release.
- VGA only: request addr 0x0010..0x0013 back-to-back with RAM model returning addr[7:0] → vga_rd_valid in cycles N+2..N+5 with data 0x10..0x13; DF_VGA=1 in cycles N+1..N+4.
- Priority: VGA request and UART write (0x0100, 0xAA) in the same cycle → VGA granted first; the write reaches the RAM on the first idle cycle; DF flags never overlap.
- Backpressure: 6 UART writes during continuous VGA reads → 4 accepted, uart_wr_ready=0, fifo_level=4; after vga_rd_req drops, all 4 are written in order over 4 cycles.
- VBLANK: vs_in=1 with 3 queued writes and no VGA requests → ST_VBLANK, 3 consecutive writes, return to ST_IDLE, fifo_level=0; VS output mirrors vs_in delayed by 1 cycle.
- Mid-op reset: assert rst_n=0 one cycle after a VGA grant with the FIFO holding 2 entries → no vga_rd_valid, FIFO emptied, no RAM write after reset.
